// File: rtl/uart_core.sv
// Full-duplex UART: runtime baud divisor, optional parity, RX/TX FIFOs on a
// host read/write handshake, and sticky frame/parity/overrun error flags.
module uart_core #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_BIT   = 11,
    parameter int FIFO_W     = 2,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                rx,
    output logic                tx,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    input  logic                clr_err,
    output logic                frame_err,
    output logic                parity_err,
    output logic                overrun_err
);

    localparam int              DEPTH   = 1 << FIFO_W;
    localparam logic [5:0]      SB_LAST = 6'(SB_TICK - 1);
    localparam logic [2:0]      N_LAST  = 3'(DBIT - 1);
    localparam logic            ODD     = (PARITY_ODD != 0);
    localparam logic            USE_PAR = (PARITY_EN != 0);
    localparam logic [FIFO_W-1:0] PTR_ONE = FIFO_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- baud generator ----------------
    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;

    assign tick = (baud_cnt >= dvsr);

    always_ff @(posedge clk) begin
        if (reset)
            baud_cnt <= '0;
        else if (tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + DVSR_BIT'(1);
    end

    // ---------------- rx synchroniser ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- receiver FSM ----------------
    state_t          rx_state, rx_state_next;
    logic [5:0]      rx_s, rx_s_next;
    logic [2:0]      rx_n, rx_n_next;
    logic [DBIT-1:0] rx_b, rx_b_next;
    logic            rx_par_bad, rx_par_bad_next;
    logic            rx_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= IDLE;
            rx_s       <= '0;
            rx_n       <= '0;
            rx_b       <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_state   <= rx_state_next;
            rx_s       <= rx_s_next;
            rx_n       <= rx_n_next;
            rx_b       <= rx_b_next;
            rx_par_bad <= rx_par_bad_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state;
        rx_s_next       = rx_s;
        rx_n_next       = rx_n;
        rx_b_next       = rx_b;
        rx_par_bad_next = rx_par_bad;
        rx_done         = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_state_next = START;
                    rx_s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s == 6'd7) begin
                        // mid-start check rejects short glitches on the line
                        if (!rx_sync) begin
                            rx_state_next = DATA;
                            rx_s_next     = '0;
                            rx_n_next     = '0;
                        end else begin
                            rx_state_next = IDLE;
                        end
                    end else begin
                        rx_s_next = rx_s + 6'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s == 6'd15) begin
                        rx_s_next = '0;
                        rx_b_next = {rx_sync, rx_b[DBIT-1:1]};
                        if (rx_n == N_LAST) begin
                            rx_state_next   = USE_PAR ? PARITY : STOP;
                            rx_par_bad_next = 1'b0;
                        end else begin
                            rx_n_next = rx_n + 3'd1;
                        end
                    end else begin
                        rx_s_next = rx_s + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (rx_s == 6'd15) begin
                        rx_s_next       = '0;
                        rx_par_bad_next = (rx_sync != ((^rx_b) ^ ODD));
                        rx_state_next   = STOP;
                    end else begin
                        rx_s_next = rx_s + 6'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s == SB_LAST) begin
                        rx_state_next = IDLE;
                        rx_done       = 1'b1;
                    end else begin
                        rx_s_next = rx_s + 6'd1;
                    end
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    // ---------------- rx completion ----------------
    logic frame_set, parity_set, overrun_set, rx_good;
    logic rx_push;
    logic rx_full_r, rx_empty_r, rx_rd_en, rx_wr_en;

    assign rx_rd_en    = rd_uart && !rx_empty_r;
    assign frame_set   = rx_done && !rx_sync;
    assign parity_set  = rx_done && rx_sync && rx_par_bad;
    assign rx_good     = rx_done && rx_sync && !rx_par_bad;
    // a same-clock host pop frees a slot, so that case is not an overrun
    assign overrun_set = rx_good && rx_full_r && !rx_rd_en;
    assign rx_push     = rx_good && !overrun_set;
    assign rx_wr_en    = rx_push;

    // ---------------- rx FIFO ----------------
    logic [DBIT-1:0]   rx_mem [DEPTH];
    logic [FIFO_W-1:0] rx_wp, rx_rp;

    always_ff @(posedge clk) begin
        if (rx_wr_en)
            rx_mem[rx_wp] <= rx_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp      <= '0;
            rx_rp      <= '0;
            rx_full_r  <= 1'b0;
            rx_empty_r <= 1'b1;
        end else begin
            if (rx_wr_en)
                rx_wp <= rx_wp + PTR_ONE;
            if (rx_rd_en)
                rx_rp <= rx_rp + PTR_ONE;
            if (rx_wr_en && !rx_rd_en) begin
                rx_empty_r <= 1'b0;
                rx_full_r  <= ((rx_wp + PTR_ONE) == rx_rp);
            end else if (rx_rd_en && !rx_wr_en) begin
                rx_full_r  <= 1'b0;
                rx_empty_r <= ((rx_rp + PTR_ONE) == rx_wp);
            end
        end
    end

    assign rx_empty = rx_empty_r;
    assign r_data   = rx_empty_r ? '0 : rx_mem[rx_rp];

    // ---------------- tx FIFO ----------------
    logic [DBIT-1:0]   tx_mem [DEPTH];
    logic [FIFO_W-1:0] tx_wp, tx_rp;
    logic              tx_full_r, tx_empty_r, tx_rd_en, tx_wr_en, tx_pop;
    logic [DBIT-1:0]   tx_head;

    assign tx_rd_en = tx_pop;
    assign tx_wr_en = wr_uart && (!tx_full_r || tx_rd_en);
    assign tx_head  = tx_mem[tx_rp];
    assign tx_full  = tx_full_r;

    always_ff @(posedge clk) begin
        if (tx_wr_en)
            tx_mem[tx_wp] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp      <= '0;
            tx_rp      <= '0;
            tx_full_r  <= 1'b0;
            tx_empty_r <= 1'b1;
        end else begin
            if (tx_wr_en)
                tx_wp <= tx_wp + PTR_ONE;
            if (tx_rd_en)
                tx_rp <= tx_rp + PTR_ONE;
            if (tx_wr_en && !tx_rd_en) begin
                tx_empty_r <= 1'b0;
                tx_full_r  <= ((tx_wp + PTR_ONE) == tx_rp);
            end else if (tx_rd_en && !tx_wr_en) begin
                tx_full_r  <= 1'b0;
                tx_empty_r <= ((tx_rp + PTR_ONE) == tx_wp);
            end
        end
    end

    // ---------------- transmitter FSM ----------------
    state_t          tx_state, tx_state_next;
    logic [5:0]      tx_s, tx_s_next;
    logic [2:0]      tx_n, tx_n_next;
    logic [DBIT-1:0] tx_b, tx_b_next;
    logic            tx_par, tx_par_next;
    logic            tx_reg, tx_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_par   <= 1'b0;
            tx_reg   <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_s     <= tx_s_next;
            tx_n     <= tx_n_next;
            tx_b     <= tx_b_next;
            tx_par   <= tx_par_next;
            tx_reg   <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_s_next     = tx_s;
        tx_n_next     = tx_n;
        tx_b_next     = tx_b;
        tx_par_next   = tx_par;
        tx_pop        = 1'b0;
        tx_next       = 1'b1;
        case (tx_state)
            IDLE: begin
                if (!tx_empty_r) begin
                    tx_pop        = 1'b1;
                    tx_b_next     = tx_head;
                    tx_par_next   = (^tx_head) ^ ODD;
                    tx_s_next     = '0;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tx_s == 6'd15) begin
                        tx_s_next     = '0;
                        tx_n_next     = '0;
                        tx_state_next = DATA;
                    end else begin
                        tx_s_next = tx_s + 6'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_s == 6'd15) begin
                        tx_s_next = '0;
                        tx_b_next = tx_b >> 1;
                        if (tx_n == N_LAST)
                            tx_state_next = USE_PAR ? PARITY : STOP;
                        else
                            tx_n_next = tx_n + 3'd1;
                    end else begin
                        tx_s_next = tx_s + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tx_s == 6'd15) begin
                        tx_s_next     = '0;
                        tx_state_next = STOP;
                    end else begin
                        tx_s_next = tx_s + 6'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_s == SB_LAST)
                        tx_state_next = IDLE;
                    else
                        tx_s_next = tx_s + 6'd1;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        // line level is registered from the upcoming state so tx has no glitches
        case (tx_state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_b_next[0];
            PARITY:  tx_next = tx_par_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx = tx_reg;

    // ---------------- sticky error flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_set)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
            if (parity_set)
                parity_err <= 1'b1;
            else if (clr_err)
                parity_err <= 1'b0;
            if (overrun_set)
                overrun_err <= 1'b1;
            else if (clr_err)
                overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: one instance without parity (loopback, framing,
// overrun, glitch, reset) and one with even parity.
module tb_uart_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] dvsr = 11'd3;

    logic       loop_a = 1'b0, rx_drv_a = 1'b1, rx_a, tx_a;
    logic       rd_uart_a = 1'b0, rx_empty_a, wr_uart_a = 1'b0, tx_full_a, clr_err_a = 1'b0;
    logic [7:0] r_data_a, w_data_a = 8'h00;
    logic       frame_err_a, parity_err_a, overrun_err_a;

    logic       rx_drv_p = 1'b1, tx_p;
    logic       rd_uart_p = 1'b0, rx_empty_p, wr_uart_p = 1'b0, tx_full_p, clr_err_p = 1'b0;
    logic [7:0] r_data_p, w_data_p = 8'h00;
    logic       frame_err_p, parity_err_p, overrun_err_p;

    assign rx_a = loop_a ? tx_a : rx_drv_a;

    uart_core #(.DBIT(8), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_a), .tx(tx_a),
        .rd_uart(rd_uart_a), .r_data(r_data_a), .rx_empty(rx_empty_a),
        .wr_uart(wr_uart_a), .w_data(w_data_a), .tx_full(tx_full_a),
        .clr_err(clr_err_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .overrun_err(overrun_err_a)
    );

    uart_core #(.DBIT(8), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_drv_p), .tx(tx_p),
        .rd_uart(rd_uart_p), .r_data(r_data_p), .rx_empty(rx_empty_p),
        .wr_uart(wr_uart_p), .w_data(w_data_p), .tx_full(tx_full_p),
        .clr_err(clr_err_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun_err(overrun_err_p)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] qa[$];
    logic [7:0] qp[$];
    logic mon_en_a = 1'b0;

    int   cyc = 0;
    int   last_fall_a = 0;
    int   fall_cnt_a = 0;
    logic tx_prev_a = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // cycle counter and tx falling-edge tracker, sampled just after each edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_prev_a === 1'b1 && tx_a === 1'b0) begin
            last_fall_a = cyc;
            fall_cnt_a++;
        end
        tx_prev_a = tx_a;
    end

    // scoreboard monitors: pop expected byte whenever the DUT presents one
    always @(negedge clk) begin : mon_a
        logic [7:0] e;
        if (mon_en_a && rx_empty_a === 1'b0) begin
            if (qa.size() == 0) begin
                total_cnt++;
                $display("FAIL rx_a_unexpected: got 0x%0h expected no byte", r_data_a);
            end else begin
                e = qa.pop_front();
                check("rx_a_data", {24'd0, r_data_a}, {24'd0, e});
            end
            rd_uart_a = 1'b1;
        end else begin
            rd_uart_a = 1'b0;
        end
    end

    always @(negedge clk) begin : mon_p
        logic [7:0] e;
        if (rx_empty_p === 1'b0) begin
            if (qp.size() == 0) begin
                total_cnt++;
                $display("FAIL rx_p_unexpected: got 0x%0h expected no byte", r_data_p);
            end else begin
                e = qp.pop_front();
                check("rx_p_data", {24'd0, r_data_p}, {24'd0, e});
            end
            rd_uart_p = 1'b1;
        end else begin
            rd_uart_p = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic drive_bit(input bit to_p, input logic v, input int n);
        if (to_p) rx_drv_p = v;
        else      rx_drv_a = v;
        repeat (n) @(negedge clk);
    endtask

    // one serial frame at 64 clocks per bit; a bad stop bit is held low for 48 clocks
    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit with_par,
                              input logic par_bit, input bit stop_low);
        drive_bit(to_p, 1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(to_p, d[i], 64);
        if (with_par) drive_bit(to_p, par_bit, 64);
        if (stop_low) begin
            drive_bit(to_p, 1'b0, 48);
            drive_bit(to_p, 1'b1, 16);
        end else begin
            drive_bit(to_p, 1'b1, 64);
        end
    endtask

    task automatic write_a(input logic [7:0] d);
        wr_uart_a = 1'b1;
        w_data_a  = d;
        @(negedge clk);
        wr_uart_a = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_fall(input string name, input int bound, output int t);
        int  start;
        bit  seen;
        start = fall_cnt_a;
        seen  = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (fall_cnt_a != start) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
        t = last_fall_a;
    endtask

    initial begin
        int t, tn, cyc_w, f0;
        logic [7:0] lb [4];
        lb[0] = 8'hA5; lb[1] = 8'h3C; lb[2] = 8'hFF; lb[3] = 8'h00;

        repeat (4) @(negedge clk);
        check("reset_tx",        {31'd0, tx_a},          32'd1);
        check("reset_rx_empty",  {31'd0, rx_empty_a},    32'd1);
        check("reset_tx_full",   {31'd0, tx_full_a},     32'd0);
        check("reset_frame_err", {31'd0, frame_err_a},   32'd0);
        check("reset_par_err",   {31'd0, parity_err_p},  32'd0);
        check("reset_ovr_err",   {31'd0, overrun_err_a}, 32'd0);
        check("reset_r_data",    {24'd0, r_data_a},      32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // loopback: four back-to-back frames, 640 clocks apart in steady state
        loop_a   = 1'b1;
        mon_en_a = 1'b1;
        f0 = fall_cnt_a;
        for (int i = 0; i < 4; i++) qa.push_back(lb[i]);
        write_a(lb[0]);
        cyc_w = cyc;
        for (int i = 1; i < 4; i++) write_a(lb[i]);
        check("tx_first_fall", {31'd0, (fall_cnt_a > f0)}, 32'd1);
        check_range("tx_start_latency", last_fall_a - cyc_w, 1, 2);
        t = last_fall_a;
        for (int k = 1; k < 4; k++) begin
            wait_until(t + 600);
            wait_fall("frame_fall", 100, tn);
            if (k == 1) check_range("frame1_len", tn - t, 638, 641);
            else        check("frame_len", tn - t, 32'd640);
            t = tn;
        end
        wait_until(t + 700);
        check("loop_all_rx", qa.size(), 32'd0);
        check("loop_rx_empty", {31'd0, rx_empty_a}, 32'd1);
        loop_a = 1'b0;

        // parity: bad parity bit rejected, correct one accepted
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        check("par_err_set",   {31'd0, parity_err_p}, 32'd1);
        check("par_rx_empty",  {31'd0, rx_empty_p},   32'd1);
        check("par_frame_err", {31'd0, frame_err_p},  32'd0);
        qp.push_back(8'h07);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("par_good_rx", qp.size(), 32'd0);
        clr_err_p = 1'b1;
        @(negedge clk);
        clr_err_p = 1'b0;
        check("par_err_clr", {31'd0, parity_err_p}, 32'd0);

        // framing error
        mon_en_a = 1'b0;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        check("frame_err_set",  {31'd0, frame_err_a}, 32'd1);
        repeat (60) @(negedge clk);
        check("frame_rx_empty", {31'd0, rx_empty_a},  32'd1);
        clr_err_a = 1'b1;
        @(negedge clk);
        clr_err_a = 1'b0;
        check("frame_err_clr",  {31'd0, frame_err_a}, 32'd0);

        // overrun: fifth byte dropped, first four kept
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) qa.push_back(8'(i));
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 4) begin
                check("ovr_not_yet",  {31'd0, overrun_err_a}, 32'd0);
                check("ovr_rx_avail", {31'd0, rx_empty_a},    32'd0);
            end
        end
        check("ovr_err_set",   {31'd0, overrun_err_a}, 32'd1);
        check("ovr_frame_err", {31'd0, frame_err_a},   32'd0);
        mon_en_a = 1'b1;
        repeat (10) @(negedge clk);
        check("ovr_drained",  qa.size(), 32'd0);
        check("ovr_rx_empty", {31'd0, rx_empty_a}, 32'd1);
        clr_err_a = 1'b1;
        @(negedge clk);
        clr_err_a = 1'b0;
        check("ovr_err_clr", {31'd0, overrun_err_a}, 32'd0);

        // glitch: 4 ticks low is not a start bit
        drive_bit(1'b0, 1'b0, 16);
        drive_bit(1'b0, 1'b1, 200);
        check("glitch_rx_empty", {31'd0, rx_empty_a},    32'd1);
        check("glitch_frame",    {31'd0, frame_err_a},   32'd0);
        check("glitch_overrun",  {31'd0, overrun_err_a}, 32'd0);

        // tx_full after five writes (one popped, four queued)
        for (int i = 0; i < 4; i++) write_a(8'h11 + 8'(i));
        check("tx_full_4", {31'd0, tx_full_a}, 32'd0);
        write_a(8'h15);
        check("tx_full_5", {31'd0, tx_full_a}, 32'd1);

        // reset in the middle of data bit 3
        t = last_fall_a;
        wait_until(t + 288);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx",       {31'd0, tx_a},       32'd1);
        check("rst_tx_full",  {31'd0, tx_full_a},  32'd0);
        check("rst_rx_empty", {31'd0, rx_empty_a}, 32'd1);
        reset = 1'b0;
        f0 = fall_cnt_a;
        repeat (100) @(negedge clk);
        check("rst_tx_quiet", fall_cnt_a - f0, 32'd0);

        loop_a = 1'b1;
        qa.push_back(8'h81);
        write_a(8'h81);
        wait_fall("post_rst_fall", 10, t);
        wait_until(t + 700);
        check("post_rst_rx", qa.size(), 32'd0);
        check("final_qp",    qp.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
